// File: rtl/framebuffer_arbiter.sv
// Arbitrates a single-port frame RAM between fixed-latency scanout reads and a FIFO-buffered host write stream.
// Optional full-frame clear engine is built when FB_CLEAR_EN is defined.
module framebuffer_arbiter #(
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 9,
  parameter int unsigned PIXEL_BITS  = 12,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clock_in,
  input  logic                              reset_n_in,
  input  logic                              rd_req_in,
  input  logic [WIDTH_BITS-1:0]             rd_x_in,
  input  logic [HEIGHT_BITS-1:0]            rd_y_in,
  output logic [PIXEL_BITS-1:0]             rd_pixel_out,
  output logic                              rd_valid_out,
  input  logic                              wr_valid_in,
  output logic                              wr_ready_out,
  input  logic [WIDTH_BITS-1:0]             wr_x_in,
  input  logic [HEIGHT_BITS-1:0]            wr_y_in,
  input  logic [PIXEL_BITS-1:0]             wr_pixel_in,
  output logic                              mem_en_out,
  output logic                              mem_we_out,
  output logic [WIDTH_BITS+HEIGHT_BITS-1:0] mem_addr_out,
  output logic [PIXEL_BITS-1:0]             mem_wdata_out,
  input  logic [PIXEL_BITS-1:0]             mem_rdata_in
`ifdef FB_CLEAR_EN
  ,
  input  logic                              clear_start_in,
  input  logic [PIXEL_BITS-1:0]             clear_color_in,
  output logic                              clear_busy_out
`endif
);

  localparam int unsigned ADDR_BITS = WIDTH_BITS + HEIGHT_BITS;
  localparam int unsigned PTR_BITS  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_BITS  = PTR_BITS + 1;

  typedef struct packed {
    logic [ADDR_BITS-1:0]  addr;
    logic [PIXEL_BITS-1:0] pixel;
  } wr_entry_t;

  wr_entry_t             fifo_mem [FIFO_DEPTH];
  wr_entry_t             head;
  logic [PTR_BITS-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_BITS-1:0]   count_q;
  logic                  fifo_full, fifo_empty, push, pop;
  logic                  clear_active, clear_grant;
  logic [ADDR_BITS-1:0]  clear_addr_q;
  logic [PIXEL_BITS-1:0] clear_color_q;
  logic                  mem_en_d, mem_we_d;
  logic [ADDR_BITS-1:0]  mem_addr_d;
  logic [PIXEL_BITS-1:0] mem_wdata_d;
  logic                  rd_stage0_q, rd_stage1_q;

  assign fifo_full    = (count_q == CNT_BITS'(FIFO_DEPTH));
  assign fifo_empty   = (count_q == '0);
  assign wr_ready_out = !fifo_full;
  assign push         = wr_valid_in && !fifo_full;
  assign head         = fifo_mem[rd_ptr_q];
  // Scanout always wins; the clear engine holds off FIFO drain while it runs.
  assign clear_grant  = !rd_req_in && clear_active;
  assign pop          = !rd_req_in && !clear_active && !fifo_empty;

`ifdef FB_CLEAR_EN
  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [ADDR_BITS-1:0]  clear_addr_d;
  logic [PIXEL_BITS-1:0] clear_color_d;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q       <= ST_IDLE;
      clear_addr_q  <= '0;
      clear_color_q <= '0;
    end else begin
      state_q       <= state_d;
      clear_addr_q  <= clear_addr_d;
      clear_color_q <= clear_color_d;
    end
  end

  // Counter only advances on cycles the clear actually owns the RAM.
  always_comb begin
    state_d       = state_q;
    clear_addr_d  = clear_addr_q;
    clear_color_d = clear_color_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_start_in) begin
          state_d       = ST_CLEAR;
          clear_addr_d  = '0;
          clear_color_d = clear_color_in;
        end
      end
      ST_CLEAR: begin
        if (clear_grant) begin
          clear_addr_d = clear_addr_q + ADDR_BITS'(1);
          if (clear_addr_q == '1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clear_active   = (state_q == ST_CLEAR);
  assign clear_busy_out = clear_active;
`else
  assign clear_active  = 1'b0;
  assign clear_addr_q  = '0;
  assign clear_color_q = '0;
`endif

  always_ff @(posedge clock_in) begin
    if (push) fifo_mem[wr_ptr_q] <= '{addr: {wr_y_in, wr_x_in}, pixel: wr_pixel_in};
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_BITS'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_BITS'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // RAM command mux; address/data hold when idle to avoid needless toggling.
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_out;
    mem_wdata_d = mem_wdata_out;
    if (rd_req_in) begin
      mem_en_d   = 1'b1;
      mem_addr_d = {rd_y_in, rd_x_in};
    end else if (clear_grant) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = clear_addr_q;
      mem_wdata_d = clear_color_q;
    end else if (pop) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = head.addr;
      mem_wdata_d = head.pixel;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      mem_en_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
    end else begin
      mem_en_out    <= mem_en_d;
      mem_we_out    <= mem_we_d;
      mem_addr_out  <= mem_addr_d;
      mem_wdata_out <= mem_wdata_d;
    end
  end

  // Fixed three-stage read return: strobe, RAM access, output register.
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      rd_stage0_q  <= 1'b0;
      rd_stage1_q  <= 1'b0;
      rd_valid_out <= 1'b0;
      rd_pixel_out <= '0;
    end else begin
      rd_stage0_q  <= rd_req_in;
      rd_stage1_q  <= rd_stage0_q;
      rd_valid_out <= rd_stage1_q;
      if (rd_stage1_q) rd_pixel_out <= mem_rdata_in;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Randomized bench for framebuffer_arbiter against a queue/array reference model.
// Define FB_CLEAR_EN to exercise the clear engine (uses a reduced frame size).
module tb_framebuffer_arbiter;

`ifdef FB_CLEAR_EN
  localparam int unsigned W = 4;
  localparam int unsigned H = 3;
`else
  localparam int unsigned W = 10;
  localparam int unsigned H = 9;
`endif
  localparam int unsigned P = 12;
  localparam int unsigned D = 4;
  localparam int unsigned A = W + H;

  logic         clock_in, reset_n_in;
  logic         rd_req_in;
  logic [W-1:0] rd_x_in;
  logic [H-1:0] rd_y_in;
  logic [P-1:0] rd_pixel_out;
  logic         rd_valid_out;
  logic         wr_valid_in, wr_ready_out;
  logic [W-1:0] wr_x_in;
  logic [H-1:0] wr_y_in;
  logic [P-1:0] wr_pixel_in;
  logic         mem_en_out, mem_we_out;
  logic [A-1:0] mem_addr_out;
  logic [P-1:0] mem_wdata_out, mem_rdata_in;
`ifdef FB_CLEAR_EN
  logic         clear_start_in, clear_busy_out;
  logic [P-1:0] clear_color_in;
`endif

  framebuffer_arbiter #(
    .WIDTH_BITS(W), .HEIGHT_BITS(H), .PIXEL_BITS(P), .FIFO_DEPTH(D)
  ) dut (
    .clock_in(clock_in), .reset_n_in(reset_n_in),
    .rd_req_in(rd_req_in), .rd_x_in(rd_x_in), .rd_y_in(rd_y_in),
    .rd_pixel_out(rd_pixel_out), .rd_valid_out(rd_valid_out),
    .wr_valid_in(wr_valid_in), .wr_ready_out(wr_ready_out),
    .wr_x_in(wr_x_in), .wr_y_in(wr_y_in), .wr_pixel_in(wr_pixel_in),
    .mem_en_out(mem_en_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in)
`ifdef FB_CLEAR_EN
    , .clear_start_in(clear_start_in), .clear_color_in(clear_color_in),
    .clear_busy_out(clear_busy_out)
`endif
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  // Synchronous single-port frame RAM fixture.
  logic [P-1:0] ram [2**A];
  always @(posedge clock_in) begin
    if (mem_en_out) begin
      if (mem_we_out) ram[mem_addr_out] <= mem_wdata_out;
      else            mem_rdata_in <= ram[mem_addr_out];
    end
  end

  // Reference model state.
  logic [A+P-1:0] wq [$];
  logic [P-1:0]   ref_mem [2**A];
  bit             ref_known [2**A];
  int             exp_rd_cyc [$];
  logic [P-1:0]   exp_rd_pix [$];
  bit             exp_rd_known [$];
  int             cyc;
  bit             clr_active;
  logic [A-1:0]   clr_ptr;
  logic [P-1:0]   clr_color;
  bit             lw_valid;
  logic [A-1:0]   lw_addr;
  int             n_vec, n_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_write(input logic [A-1:0] a, input logic [P-1:0] d);
    check_eq("bus_en", 32'(mem_en_out), 32'd1);
    check_eq("bus_we", 32'(mem_we_out), 32'd1);
    check_eq("bus_waddr", 32'(mem_addr_out), 32'(a));
    check_eq("bus_wdata", 32'(mem_wdata_out), 32'(d));
    ref_mem[a]   = d;
    ref_known[a] = 1'b1;
    lw_valid     = 1'b1;
    lw_addr      = a;
  endtask

  // One clock: drive at negedge, then check bus/outputs just after posedge.
  task automatic step(input logic rd, input logic [W-1:0] rx, input logic [H-1:0] ry,
                      input logic wv, input logic [W-1:0] wx, input logic [H-1:0] wy,
                      input logic [P-1:0] wp, input logic cs, input logic [P-1:0] cc);
    int           n_before;
    bit           clr_before, push_exp;
    logic [A-1:0] a;
    logic [A+P-1:0] e;
    @(negedge clock_in);
    rd_req_in = rd; rd_x_in = rx; rd_y_in = ry;
    wr_valid_in = wv; wr_x_in = wx; wr_y_in = wy; wr_pixel_in = wp;
`ifdef FB_CLEAR_EN
    clear_start_in = cs; clear_color_in = cc;
`endif
    check_eq("wr_ready", 32'(wr_ready_out), 32'(wq.size() < D));
    push_exp   = wv && (wq.size() < D);
    n_before   = wq.size();
    clr_before = clr_active;
    @(posedge clock_in);
    #1;
    cyc++;
    lw_valid = 1'b0;
    if (rd) begin
      a = {ry, rx};
      check_eq("bus_en", 32'(mem_en_out), 32'd1);
      check_eq("bus_we_rd", 32'(mem_we_out), 32'd0);
      check_eq("bus_raddr", 32'(mem_addr_out), 32'(a));
      exp_rd_cyc.push_back(cyc + 2);
      exp_rd_pix.push_back(ref_mem[a]);
      exp_rd_known.push_back(ref_known[a]);
    end else if (clr_before) begin
      model_write(clr_ptr, clr_color);
      if (clr_ptr == '1) clr_active = 1'b0;
      clr_ptr = clr_ptr + A'(1);
    end else if (n_before > 0) begin
      e = wq.pop_front();
      model_write(e[A+P-1:P], e[P-1:0]);
    end else begin
      check_eq("bus_idle", 32'(mem_en_out), 32'd0);
    end
    if (push_exp) wq.push_back({wy, wx, wp});
`ifdef FB_CLEAR_EN
    if (cs && !clr_before) begin
      clr_active = 1'b1;
      clr_ptr    = '0;
      clr_color  = cc;
    end
    check_eq("clear_busy", 32'(clear_busy_out), 32'(clr_active));
`else
    if (cs) clr_color = cc;
`endif
    if (exp_rd_cyc.size() > 0 && exp_rd_cyc[0] == cyc) begin
      check_eq("rd_valid", 32'(rd_valid_out), 32'd1);
      if (exp_rd_known[0]) check_eq("rd_pixel", 32'(rd_pixel_out), 32'(exp_rd_pix[0]));
      void'(exp_rd_cyc.pop_front());
      void'(exp_rd_pix.pop_front());
      void'(exp_rd_known.pop_front());
    end else begin
      check_eq("rd_valid_idle", 32'(rd_valid_out), 32'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, '0, 0, '0);
  endtask

  task automatic rnd_step(input int rd_pct, input int wv_pct, input int cs_pct);
    step($urandom_range(99) < rd_pct, W'($urandom), H'($urandom),
         $urandom_range(99) < wv_pct, W'($urandom), H'($urandom), P'($urandom),
         $urandom_range(99) < cs_pct, P'($urandom));
  endtask

  // Async reset between edges; outputs must fall immediately.
  task automatic do_reset();
    @(negedge clock_in);
    rd_req_in = 0; wr_valid_in = 0;
`ifdef FB_CLEAR_EN
    clear_start_in = 0;
`endif
    #2;
    reset_n_in = 1'b0;
    #1;
    check_eq("rst_rd_valid", 32'(rd_valid_out), 32'd0);
    check_eq("rst_rd_pixel", 32'(rd_pixel_out), 32'd0);
    check_eq("rst_mem_en", 32'(mem_en_out), 32'd0);
    check_eq("rst_mem_we", 32'(mem_we_out), 32'd0);
    check_eq("rst_mem_addr", 32'(mem_addr_out), 32'd0);
    check_eq("rst_mem_wdata", 32'(mem_wdata_out), 32'd0);
    check_eq("rst_wr_ready", 32'(wr_ready_out), 32'd1);
`ifdef FB_CLEAR_EN
    check_eq("rst_clear_busy", 32'(clear_busy_out), 32'd0);
`endif
    // A write on the bus at reset never reaches the RAM.
    if (lw_valid) ref_known[lw_addr] = 1'b0;
    lw_valid = 1'b0;
    wq.delete();
    exp_rd_cyc.delete();
    exp_rd_pix.delete();
    exp_rd_known.delete();
    clr_active = 1'b0;
    repeat (2) @(negedge clock_in);
    reset_n_in = 1'b1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    clr_active = 0; clr_ptr = '0; clr_color = '0; lw_valid = 0; lw_addr = '0;
    reset_n_in = 1'b0;
    rd_req_in = 0; rd_x_in = '0; rd_y_in = '0;
    wr_valid_in = 0; wr_x_in = '0; wr_y_in = '0; wr_pixel_in = '0;
`ifdef FB_CLEAR_EN
    clear_start_in = 0; clear_color_in = '0;
`endif
    do_reset();

    // Load 0xABC at (x=7,y=5), then read it back with 3-cycle latency.
    step(0, '0, '0, 1, W'(7), H'(5), P'(12'hABC), 0, '0);
    idle(2);
    step(1, W'(7), H'(5), 0, '0, '0, '0, 0, '0);
    idle(3);

    // Fill FIFO behind a held read stream, then drain in order.
    for (int i = 0; i < 5; i++)
      step(1, W'($urandom), H'($urandom), 1, W'(i + 1), H'(i), P'(12'h100 + i), 0, '0);
    idle(6);

    // Alternating reads with a full FIFO: writes only in the gaps.
    for (int i = 0; i < 4; i++)
      step(1, W'($urandom), H'($urandom), 1, W'($urandom), H'($urandom), P'($urandom), 0, '0);
    for (int i = 0; i < 14; i++)
      step(i % 2 == 0, W'($urandom), H'($urandom), $urandom_range(1), W'($urandom), H'($urandom),
           P'($urandom), 0, '0);
    idle(6);

    // Write-then-read same pixel.
    step(0, '0, '0, 1, W'(3), H'(2), P'(12'h123), 0, '0);
    idle(1);
    step(1, W'(3), H'(2), 0, '0, '0, '0, 0, '0);
    idle(3);

`ifdef FB_CLEAR_EN
    // Clear to 0xF00 with one host write pushed mid-clear.
    step(0, '0, '0, 0, '0, '0, '0, 1, P'(12'hF00));
    for (int i = 0; i < 5; i++) rnd_step(30, 0, 50);
    step(0, '0, '0, 1, W'(1), H'(0), P'(12'h0F0), 0, '0);
    for (int i = 0; i < 2**A + 200 && clr_active; i++) rnd_step(25, 0, 20);
    check_eq("clear_finished", 32'(clear_busy_out), 32'd0);
    idle(3);
    for (int i = 0; i < 2**A; i++) begin
      logic [A-1:0] a;
      a = A'(i);
      step(1, a[W-1:0], a[A-1:W], 0, '0, '0, '0, 0, '0);
    end
    idle(3);
`endif

    // Reset with queued writes (and a clear pending behind reads).
    for (int i = 0; i < 3; i++)
      step(1, W'($urandom), H'($urandom), 1, W'($urandom), H'($urandom), P'($urandom), 0, '0);
    step(1, W'($urandom), H'($urandom), 0, '0, '0, '0, 1, P'(12'h0AA));
    do_reset();
    idle(6);

    // Randomized traffic in a few regimes.
    for (int i = 0; i < 600; i++) rnd_step(50, 60, 0);
    for (int i = 0; i < 600; i++) rnd_step(90, 70, 1);
    for (int i = 0; i < 600; i++) rnd_step(20, 40, 1);
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
